// File: rtl/regfile_wb_scheduler_if.sv
// Bundle of issue-stage, writeback-requester and register-file write-port signals
// shared between the writeback scheduler and its neighbours.
interface regfile_wb_scheduler_if #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 64
);
   logic                    flush;
   logic                    issue_valid;
   logic [4:0]              issue_rd;
   logic                    issue_ready;
   logic [4:0]              rs1_addr;
   logic [4:0]              rs2_addr;
   logic                    rs1_busy;
   logic                    rs2_busy;
   logic [NUM_REQ-1:0]      wb_valid;
   logic [NUM_REQ*5-1:0]    wb_rd;
   logic [NUM_REQ*XLEN-1:0] wb_data;
   logic [NUM_REQ-1:0]      wb_ready;
   logic                    rf_wen;
   logic [4:0]              rf_addr;
   logic [XLEN-1:0]         rf_data;

   modport master (
      output flush, issue_valid, issue_rd, rs1_addr, rs2_addr,
      output wb_valid, wb_rd, wb_data,
      input  issue_ready, rs1_busy, rs2_busy, wb_ready,
      input  rf_wen, rf_addr, rf_data
   );

   modport slave (
      input  flush, issue_valid, issue_rd, rs1_addr, rs2_addr,
      input  wb_valid, wb_rd, wb_data,
      output issue_ready, rs1_busy, rs2_busy, wb_ready,
      output rf_wen, rf_addr, rf_data
   );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin arbiter for the single register-file write port, plus the
// per-register busy scoreboard that reports RAW/WAW hazards to issue.
module regfile_wb_scheduler #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 64
) (
   input  logic                  clk,
   input  logic                  rst_n,
   regfile_wb_scheduler_if.slave bus
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

   logic [PTR_W-1:0]   rr_ptr_r;
   logic [PTR_W-1:0]   rr_ptr_n_s;
   logic [PTR_W:0]     pick_s;
   logic [PTR_W-1:0]   winner_s;
   logic               hs_s;
   logic [NUM_REQ-1:0] grant_s;
   logic [4:0]         win_rd_s;
   logic [XLEN-1:0]    win_data_s;
   logic [31:0]        busy_r;
   logic [31:0]        busy_n_s;
   logic               rf_wen_r;
   logic [4:0]         rf_addr_r;
   logic [XLEN-1:0]    rf_data_r;
   logic               clr_hit_s;
   logic               issue_ready_s;
   logic               issue_fire_s;

   // Returns {found, index} of the first set request at or after ptr, wrapping.
   // Walking the offsets backwards lets the nearest request overwrite farther ones.
   function automatic logic [PTR_W:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [PTR_W-1:0]   ptr);
      logic [PTR_W:0]   pick;
      logic [PTR_W:0]   sum;
      logic [PTR_W-1:0] idx;
      pick = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         sum = (sum >= NUM_REQ_W) ? (sum - NUM_REQ_W) : sum;
         idx = sum[PTR_W-1:0];
         if (req[idx]) begin
            pick = {1'b1, idx};
         end else begin
            pick = pick;
         end
      end
      return pick;
   endfunction

   // Arbitration: pick winner, build one-hot grant, select its rd/data.
   always_comb begin
      grant_s    = '0;
      pick_s     = rr_pick(bus.wb_valid, rr_ptr_r);
      winner_s   = pick_s[PTR_W-1:0];
      hs_s       = pick_s[PTR_W] & rst_n;
      win_rd_s   = bus.wb_rd[5*winner_s +: 5];
      win_data_s = bus.wb_data[XLEN*winner_s +: XLEN];
      if (hs_s) begin
         grant_s[winner_s] = 1'b1;
      end else begin
         grant_s = '0;
      end
   end

   // Next round-robin pointer: one past the winner on handshake, else hold.
   always_comb begin
      rr_ptr_n_s = rr_ptr_r;
      if (hs_s) begin
         if (({1'b0, winner_s} + (PTR_W+1)'(1)) == NUM_REQ_W) begin
            rr_ptr_n_s = '0;
         end else begin
            rr_ptr_n_s = winner_s + PTR_W'(1);
         end
      end else begin
         rr_ptr_n_s = rr_ptr_r;
      end
   end

   // Round-robin pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rr_ptr_r <= '0;
      end else begin
         rr_ptr_r <= rr_ptr_n_s;
      end
   end

   // Write pipeline: winner appears on the rf_* port one cycle after handshake.
   // A winner targeting x0 consumes the slot but produces no write.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_wen_r  <= 1'b0;
         rf_addr_r <= 5'd0;
         rf_data_r <= '0;
      end else if (hs_s && (win_rd_s != 5'd0)) begin
         rf_wen_r  <= 1'b1;
         rf_addr_r <= win_rd_s;
         rf_data_r <= win_data_s;
      end else begin
         rf_wen_r  <= 1'b0;
      end
   end

   // Issue acceptance: WAW stalls unless the pending write commits this edge.
   always_comb begin
      clr_hit_s     = rf_wen_r && (rf_addr_r == bus.issue_rd);
      issue_ready_s = !bus.flush &&
                      ((bus.issue_rd == 5'd0) || !busy_r[bus.issue_rd] || clr_hit_s);
      issue_fire_s  = bus.issue_valid && issue_ready_s && (bus.issue_rd != 5'd0);
   end

   // Scoreboard next state: clear on commit, then set on issue so set wins.
   always_comb begin
      busy_n_s = busy_r;
      if (rf_wen_r) begin
         busy_n_s[rf_addr_r] = 1'b0;
      end else begin
         busy_n_s = busy_n_s;
      end
      if (issue_fire_s) begin
         busy_n_s[bus.issue_rd] = 1'b1;
      end else begin
         busy_n_s = busy_n_s;
      end
      if (bus.flush) begin
         busy_n_s = '0;
      end else begin
         busy_n_s = busy_n_s;
      end
      busy_n_s[0] = 1'b0;
   end

   // Scoreboard register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_r <= 32'd0;
      end else begin
         busy_r <= busy_n_s;
      end
   end

   // Grant is forced low while reset is asserted so requesters see no handshake.
   always_comb begin
      if (rst_n) begin
         bus.wb_ready = grant_s;
      end else begin
         bus.wb_ready = '0;
      end
   end

   assign bus.issue_ready = issue_ready_s;
   assign bus.rs1_busy    = (bus.rs1_addr != 5'd0) && busy_r[bus.rs1_addr];
   assign bus.rs2_busy    = (bus.rs2_addr != 5'd0) && busy_r[bus.rs2_addr];
   assign bus.rf_wen      = rf_wen_r;
   assign bus.rf_addr     = rf_addr_r;
   assign bus.rf_data     = rf_data_r;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed scenarios plus a randomized run against a queue-free reference model
// of the arbiter, write pipeline and busy scoreboard.
module tb_regfile_wb_scheduler;
   localparam int NUM_REQ = 3;
   localparam int XLEN    = 64;

   logic clk = 1'b0;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   regfile_wb_scheduler_if #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) bus ();

   regfile_wb_scheduler #(.NUM_REQ(NUM_REQ), .XLEN(XLEN)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      bus.flush       = 1'b0;
      bus.issue_valid = 1'b0;
      bus.issue_rd    = 5'd0;
      bus.rs1_addr    = 5'd0;
      bus.rs2_addr    = 5'd0;
      bus.wb_valid    = '0;
      bus.wb_rd       = '0;
      bus.wb_data     = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      tick();
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_wb(input int i, input logic [4:0] rd, input logic [XLEN-1:0] d);
      bus.wb_rd[i*5 +: 5]         = rd;
      bus.wb_data[i*XLEN +: XLEN] = d;
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL reset_rf_wen: got %0b expected 0", bus.rf_wen); end
      n_checks++; if (bus.rf_addr !== 5'd0) begin n_fail++; $display("FAIL reset_rf_addr: got %0d expected 0", bus.rf_addr); end
      n_checks++; if (bus.rf_data !== 64'd0) begin n_fail++; $display("FAIL reset_rf_data: got %h expected 0", bus.rf_data); end
      n_checks++; if (bus.wb_ready !== 3'b000) begin n_fail++; $display("FAIL reset_wb_ready: got %b expected 000", bus.wb_ready); end
      for (int a = 0; a < 32; a++) begin
         bus.rs1_addr = 5'(a);
         bus.rs2_addr = 5'(31 - a);
         #1;
         n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy x%0d: got %0b%0b expected 00", a, bus.rs1_busy, bus.rs2_busy);
         end
      end
      bus.wb_valid = 3'b111;
      #1;
      n_checks++; if (bus.wb_ready !== 3'b001) begin n_fail++; $display("FAIL reset_first_grant: got %b expected 001", bus.wb_ready); end
      idle_inputs();
   endtask

   task automatic test_busy_tracking();
      do_reset();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd5; bus.rs1_addr = 5'd5;
      #1;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL t1_issue_ready: got %0b expected 1", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0;
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL t1_rs1_busy_set: got %0b expected 1", bus.rs1_busy); end
      bus.wb_valid = 3'b010; set_wb(1, 5'd5, 64'hDEAD);
      #1;
      n_checks++; if (bus.wb_ready !== 3'b010) begin n_fail++; $display("FAIL t1_wb_ready: got %b expected 010", bus.wb_ready); end
      tick();
      bus.wb_valid = 3'b000;
      #1;
      n_checks++; if (bus.rf_wen !== 1'b1) begin n_fail++; $display("FAIL t1_rf_wen: got %0b expected 1", bus.rf_wen); end
      n_checks++; if (bus.rf_addr !== 5'd5) begin n_fail++; $display("FAIL t1_rf_addr: got %0d expected 5", bus.rf_addr); end
      n_checks++; if (bus.rf_data !== 64'hDEAD) begin n_fail++; $display("FAIL t1_rf_data: got %h expected dead", bus.rf_data); end
      n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL t1_rs1_busy_n1: got %0b expected 1", bus.rs1_busy); end
      tick();
      n_checks++; if (bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL t1_rs1_busy_n2: got %0b expected 0", bus.rs1_busy); end
      n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL t1_rf_wen_idle: got %0b expected 0", bus.rf_wen); end
      idle_inputs();
   endtask

   task automatic test_round_robin();
      logic [2:0] exp_g [4] = '{3'b001, 3'b010, 3'b100, 3'b001};
      logic [4:0] exp_a [4] = '{5'd1, 5'd2, 5'd3, 5'd1};
      do_reset();
      set_wb(0, 5'd1, 64'h100); set_wb(1, 5'd2, 64'h200); set_wb(2, 5'd3, 64'h300);
      bus.wb_valid = 3'b111;
      for (int k = 0; k < 4; k++) begin
         #1;
         n_checks++; if (bus.wb_ready !== exp_g[k]) begin n_fail++; $display("FAIL t2_grant[%0d]: got %b expected %b", k, bus.wb_ready, exp_g[k]); end
         if (k > 0) begin
            n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addr !== exp_a[k-1]) begin
               n_fail++; $display("FAIL t2_rf_addr[%0d]: got wen=%0b addr=%0d expected wen=1 addr=%0d", k-1, bus.rf_wen, bus.rf_addr, exp_a[k-1]);
            end
         end
         tick();
      end
      bus.wb_valid = 3'b000;
      n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addr !== exp_a[3] || bus.rf_data !== 64'h100) begin
         n_fail++; $display("FAIL t2_rf_last: got wen=%0b addr=%0d data=%h expected wen=1 addr=1 data=100", bus.rf_wen, bus.rf_addr, bus.rf_data);
      end
      idle_inputs();
   endtask

   task automatic test_waw();
      do_reset();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
      #1;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL t3_first_issue: got %0b expected 1", bus.issue_ready); end
      tick();
      #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL t3_waw_stall: got %0b expected 0", bus.issue_ready); end
      bus.wb_valid = 3'b001; set_wb(0, 5'd7, 64'h77);
      #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL t3_stall_during_hs: got %0b expected 0", bus.issue_ready); end
      tick();
      bus.wb_valid = 3'b000;
      #1;
      n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addr !== 5'd7) begin n_fail++; $display("FAIL t3_rf_write: got wen=%0b addr=%0d expected wen=1 addr=7", bus.rf_wen, bus.rf_addr); end
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL t3_clr_hit_ready: got %0b expected 1", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0; bus.rs1_addr = 5'd7;
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b1) begin n_fail++; $display("FAIL t3_set_wins: got %0b expected 1", bus.rs1_busy); end
      idle_inputs();
   endtask

   task automatic test_x0();
      do_reset();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd0; bus.rs1_addr = 5'd0; bus.rs2_addr = 5'd0;
      #1;
      n_checks++; if (bus.issue_ready !== 1'b1) begin n_fail++; $display("FAIL t4_issue_x0: got %0b expected 1", bus.issue_ready); end
      tick();
      bus.issue_valid = 1'b0;
      #1;
      n_checks++; if (bus.rs2_busy !== 1'b0 || bus.rs1_busy !== 1'b0) begin n_fail++; $display("FAIL t4_x0_busy: got %0b%0b expected 00", bus.rs1_busy, bus.rs2_busy); end
      bus.wb_valid = 3'b100; set_wb(2, 5'd0, 64'hABC);
      #1;
      n_checks++; if (bus.wb_ready !== 3'b100) begin n_fail++; $display("FAIL t4_wb_x0_ready: got %b expected 100", bus.wb_ready); end
      tick();
      bus.wb_valid = 3'b000;
      #1;
      n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL t4_wb_x0_wen: got %0b expected 0", bus.rf_wen); end
      idle_inputs();
   endtask

   task automatic test_flush();
      do_reset();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
      tick();
      bus.issue_rd = 5'd9;
      tick();
      bus.issue_valid = 1'b0; bus.rs1_addr = 5'd3; bus.rs2_addr = 5'd9;
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b1 || bus.rs2_busy !== 1'b1) begin n_fail++; $display("FAIL t5_pre_busy: got %0b%0b expected 11", bus.rs1_busy, bus.rs2_busy); end
      bus.flush = 1'b1; bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
      bus.wb_valid = 3'b001; set_wb(0, 5'd4, 64'h44);
      #1;
      n_checks++; if (bus.issue_ready !== 1'b0) begin n_fail++; $display("FAIL t5_flush_issue_ready: got %0b expected 0", bus.issue_ready); end
      n_checks++; if (bus.wb_ready !== 3'b001) begin n_fail++; $display("FAIL t5_flush_grant: got %b expected 001", bus.wb_ready); end
      tick();
      bus.flush = 1'b0; bus.issue_valid = 1'b0; bus.wb_valid = 3'b000;
      #1;
      n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL t5_post_busy: got %0b%0b expected 00", bus.rs1_busy, bus.rs2_busy); end
      n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addr !== 5'd4 || bus.rf_data !== 64'h44) begin
         n_fail++; $display("FAIL t5_inflight_write: got wen=%0b addr=%0d data=%h expected wen=1 addr=4 data=44", bus.rf_wen, bus.rf_addr, bus.rf_data);
      end
      idle_inputs();
   endtask

   task automatic test_reset_mid();
      do_reset();
      bus.issue_valid = 1'b1; bus.issue_rd = 5'd12;
      set_wb(0, 5'd1, 64'h11); set_wb(1, 5'd2, 64'h22); set_wb(2, 5'd3, 64'h33);
      bus.wb_valid = 3'b111;
      tick();
      bus.issue_valid = 1'b0; bus.rs1_addr = 5'd12; bus.rs2_addr = 5'd12;
      tick();
      #2;
      rst_n = 1'b0;
      #1;
      n_checks++; if (bus.rf_wen !== 1'b0) begin n_fail++; $display("FAIL t6_rf_wen: got %0b expected 0", bus.rf_wen); end
      n_checks++; if (bus.rs1_busy !== 1'b0 || bus.rs2_busy !== 1'b0) begin n_fail++; $display("FAIL t6_busy: got %0b%0b expected 00", bus.rs1_busy, bus.rs2_busy); end
      n_checks++; if (bus.wb_ready !== 3'b000) begin n_fail++; $display("FAIL t6_wb_ready: got %b expected 000", bus.wb_ready); end
      #2;
      rst_n = 1'b1;
      #1;
      n_checks++; if (bus.wb_ready !== 3'b001) begin n_fail++; $display("FAIL t6_first_grant: got %b expected 001", bus.wb_ready); end
      tick();
      n_checks++; if (bus.rf_wen !== 1'b1 || bus.rf_addr !== 5'd1) begin n_fail++; $display("FAIL t6_first_write: got wen=%0b addr=%0d expected wen=1 addr=1", bus.rf_wen, bus.rf_addr); end
      idle_inputs();
   endtask

   task automatic test_random();
      logic [31:0]     mbusy;
      int              mptr;
      logic            m_wen;
      logic [4:0]      m_addr;
      logic [XLEN-1:0] m_data;
      logic            rv   [NUM_REQ];
      logic [4:0]      rrd  [NUM_REQ];
      logic [XLEN-1:0] rdat [NUM_REQ];
      logic [NUM_REQ-1:0] exp_ready;
      logic            exp_ir, exp_b1, exp_b2;
      int              g;
      do_reset();
      mbusy = 32'd0; mptr = 0; m_wen = 1'b0; m_addr = 5'd0; m_data = '0;
      for (int i = 0; i < NUM_REQ; i++) begin rv[i] = 1'b0; rrd[i] = 5'd0; rdat[i] = '0; end
      for (int cyc = 0; cyc < 600; cyc++) begin
         n_checks++; if (bus.rf_wen !== m_wen) begin n_fail++; $display("FAIL rnd_rf_wen c%0d: got %0b expected %0b", cyc, bus.rf_wen, m_wen); end
         if (m_wen) begin
            n_checks++; if (bus.rf_addr !== m_addr || bus.rf_data !== m_data) begin
               n_fail++; $display("FAIL rnd_rf_port c%0d: got %0d/%h expected %0d/%h", cyc, bus.rf_addr, bus.rf_data, m_addr, m_data);
            end
         end
         for (int i = 0; i < NUM_REQ; i++) begin
            if (!rv[i]) begin
               rv[i]   = ($urandom_range(0, 99) < 60);
               rrd[i]  = 5'($urandom_range(0, 15));
               rdat[i] = {$urandom, $urandom};
            end
            bus.wb_valid[i] = rv[i];
            set_wb(i, rrd[i], rdat[i]);
         end
         bus.issue_valid = ($urandom_range(0, 1) == 1);
         bus.issue_rd    = 5'($urandom_range(0, 15));
         bus.rs1_addr    = 5'($urandom_range(0, 15));
         bus.rs2_addr    = 5'($urandom_range(0, 15));
         bus.flush       = ($urandom_range(0, 39) == 0);
         #1;
         g = -1;
         for (int k = 0; k < NUM_REQ; k++) begin
            if (g < 0 && rv[(mptr + k) % NUM_REQ]) g = (mptr + k) % NUM_REQ;
         end
         exp_ready = '0;
         if (g >= 0) exp_ready[g] = 1'b1;
         exp_ir = !bus.flush && (bus.issue_rd == 5'd0 || !mbusy[bus.issue_rd] || (m_wen && m_addr == bus.issue_rd));
         exp_b1 = (bus.rs1_addr != 5'd0) && mbusy[bus.rs1_addr];
         exp_b2 = (bus.rs2_addr != 5'd0) && mbusy[bus.rs2_addr];
         n_checks++; if (bus.wb_ready !== exp_ready) begin n_fail++; $display("FAIL rnd_grant c%0d: got %b expected %b", cyc, bus.wb_ready, exp_ready); end
         n_checks++; if (bus.issue_ready !== exp_ir) begin n_fail++; $display("FAIL rnd_issue_ready c%0d: got %0b expected %0b", cyc, bus.issue_ready, exp_ir); end
         n_checks++; if (bus.rs1_busy !== exp_b1 || bus.rs2_busy !== exp_b2) begin
            n_fail++; $display("FAIL rnd_rs_busy c%0d: got %0b%0b expected %0b%0b", cyc, bus.rs1_busy, bus.rs2_busy, exp_b1, exp_b2);
         end
         if (m_wen) mbusy[m_addr] = 1'b0;
         if (bus.issue_valid && exp_ir && bus.issue_rd != 5'd0) mbusy[bus.issue_rd] = 1'b1;
         if (bus.flush) mbusy = 32'd0;
         if (g >= 0) begin
            m_wen = (rrd[g] != 5'd0);
            if (m_wen) begin m_addr = rrd[g]; m_data = rdat[g]; end
            mptr  = (g + 1) % NUM_REQ;
            rv[g] = 1'b0;
         end else begin
            m_wen = 1'b0;
         end
         tick();
      end
      idle_inputs();
   endtask

   initial begin
      rst_n = 1'b1;
      idle_inputs();
      test_reset();
      test_busy_tracking();
      test_round_robin();
      test_waw();
      test_x0();
      test_flush();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
